prince_slayer_serial: RTL and testbench

Nibble-serial PRINCE substitution layer: accepts a 64-bit cipher state, applies the PRINCE S-box or its inverse to all 16 nibbles over several cycles, and returns the substituted state. It sits in the round datapath between key/round-constant addition and the linear (M/M') layer. It trades area for latency: it instantiates only LANES 4-bit S-box lookups instead of sixteen. Valid/ready handshakes on both sides let the round controller stall it.

---
 rtl/prince_slayer_serial.sv | 128 ++++++++++++
 tb/tb_prince_slayer_serial.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/prince_slayer_serial.sv
// prince_slayer_serial
// Nibble-serial PRINCE substitution layer. A 64-bit state is latched on the
// input handshake. LANES nibbles per cycle are then passed through S (or
// S^-1, chosen by in_inverse at acceptance), lowest group first. The result
// is held until the downstream handshake completes.
//
// Ports
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   in_valid    upstream presents a state
//   in_ready    block is idle and can accept a state
//   in_data     64-bit state, nibble k = bits 4k+3:4k
//   in_inverse  0: S, 1: S^-1 (sampled with in_data)
//   out_valid   out_data holds a finished result
//   out_ready   downstream accepts the result
//   out_data    substituted state
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | in_ready=1, waiting for an input handshake
// BUSY  | substituting group cnt of the working register, one group per cycle
// DONE  | first cycle raises out_valid, then holds until out_ready

module prince_slayer_serial #(
    parameter int LANES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_data,
    input  logic        in_inverse,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data
);

    localparam int N  = 16 / LANES;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [63:0]   work;
    logic [63:0]   work_sub;
    logic          mode;
    logic [5:0]    pos;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hB;  4'h1: y = 4'hF;  4'h2: y = 4'h3;  4'h3: y = 4'h2;
            4'h4: y = 4'hA;  4'h5: y = 4'hC;  4'h6: y = 4'h9;  4'h7: y = 4'h1;
            4'h8: y = 4'h6;  4'h9: y = 4'h7;  4'hA: y = 4'h8;  4'hB: y = 4'h0;
            4'hC: y = 4'hE;  4'hD: y = 4'h5;  4'hE: y = 4'hD;  default: y = 4'h4;
        endcase
        return y;
    endfunction

    function automatic logic [3:0] sbox_inv(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hB;  4'h1: y = 4'h7;  4'h2: y = 4'h3;  4'h3: y = 4'h2;
            4'h4: y = 4'hF;  4'h5: y = 4'hD;  4'h6: y = 4'h8;  4'h7: y = 4'h9;
            4'h8: y = 4'hA;  4'h9: y = 4'h6;  4'hA: y = 4'h4;  4'hB: y = 4'h0;
            4'hC: y = 4'h5;  4'hD: y = 4'hE;  4'hE: y = 4'hC;  default: y = 4'h1;
        endcase
        return y;
    endfunction

    // Only LANES lookups exist; cnt steers them onto the current group.
    always_comb begin
        work_sub = work;
        pos      = '0;
        for (int l = 0; l < LANES; l++) begin
            pos = 6'((int'(cnt) * LANES + l) * 4);
            work_sub[pos +: 4] = mode ? sbox_inv(work[pos +: 4]) : sbox(work[pos +: 4]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            work      <= '0;
            mode      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        work  <= in_data;
                        mode  <= in_inverse;
                        cnt   <= '0;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    work <= work_sub;
                    // Final group: park the counter rather than let it wrap.
                    if (cnt == LAST) begin
                        cnt   <= '0;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    // out_valid is a register, so the handshake is only
                    // honoured once it has actually been presented.
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready = (state == IDLE);
    assign out_data = work;

endmodule

// File: tb/tb_prince_slayer_serial.sv
// Testbench for prince_slayer_serial. Five instances (LANES 1,2,4,8,16) share
// the input side; instance 2 (LANES=4) carries the backpressure and reset
// scenarios. Results are compared against a table-driven nibble model.

module tb_prince_slayer_serial;

    localparam int NI   = 5;
    localparam int MAIN = 2;

    localparam logic [3:0] SF [16] = '{4'hB, 4'hF, 4'h3, 4'h2, 4'hA, 4'hC, 4'h9, 4'h1,
                                       4'h6, 4'h7, 4'h8, 4'h0, 4'hE, 4'h5, 4'hD, 4'h4};
    localparam logic [3:0] SI [16] = '{4'hB, 4'h7, 4'h3, 4'h2, 4'hF, 4'hD, 4'h8, 4'h9,
                                       4'hA, 4'h6, 4'h4, 4'h0, 4'h5, 4'hE, 4'hC, 4'h1};

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_inverse;
    logic        out_ready;
    logic [63:0] in_data;
    logic        ir [NI];
    logic        ov [NI];
    logic [63:0] od [NI];

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [63:0] res [NI];
    int          lat [NI];

    always #5 clk = ~clk;

    genvar g;
    generate
        for (g = 0; g < NI; g++) begin : g_dut
            prince_slayer_serial #(.LANES(1 << g)) u_dut (
                .clk        (clk),
                .rst        (rst),
                .in_valid   (in_valid),
                .in_ready   (ir[g]),
                .in_data    (in_data),
                .in_inverse (in_inverse),
                .out_valid  (ov[g]),
                .out_ready  (out_ready),
                .out_data   (od[g])
            );
        end
    endgenerate

    function automatic logic [63:0] ref_sub(input logic [63:0] d, input logic inv);
        logic [63:0] r;
        for (int k = 0; k < 16; k++)
            r[4*k +: 4] = inv ? SI[d[4*k +: 4]] : SF[d[4*k +: 4]];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        n_assert++;
        n_fail++;
        $error("FAIL %s timed out", tag);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_all_idle();
        for (int c = 0; c < 60; c++) begin
            if (ir[0] && ir[1] && ir[2] && ir[3] && ir[4]) return;
            tick();
        end
        timeout("wait_idle");
    endtask

    task automatic wait_main_valid();
        for (int c = 0; c < 30; c++) begin
            if (ov[MAIN]) return;
            tick();
        end
        timeout("wait_out_valid");
    endtask

    // One transaction on all instances; inputs are scrambled every cycle
    // after acceptance to show they are not re-sampled.
    task automatic send(input logic [63:0] d, input logic inv);
        bit all_seen;
        wait_all_idle();
        in_data    = d;
        in_inverse = inv;
        in_valid   = 1'b1;
        out_ready  = 1'b1;
        for (int i = 0; i < NI; i++) lat[i] = -1;
        tick();
        in_valid = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            in_data    = {$urandom, $urandom};
            in_inverse = 1'($urandom_range(0, 1));
            tick();
            all_seen = 1'b1;
            for (int i = 0; i < NI; i++) begin
                if (ov[i] === 1'b1 && lat[i] < 0) begin
                    lat[i] = c;
                    res[i] = od[i];
                end
                if (lat[i] < 0) all_seen = 1'b0;
            end
            if (all_seen) break;
        end
    endtask

    task automatic check_all(input string tag, input logic [63:0] d, input logic inv);
        logic [63:0] exp;
        exp = ref_sub(d, inv);
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("%s_data_l%0d", tag, 1 << i), res[i], exp);
            chk($sformatf("%s_lat_l%0d", tag, 1 << i), 64'(lat[i]), 64'(16 / (1 << i) + 1));
        end
    endtask

    task automatic no_output(input string tag);
        int seen;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (ov[MAIN] !== 1'b0) seen++;
        end
        chk(tag, 64'(seen), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] d, exp, mid;
        logic        inv;

        rst        = 1'b1;
        in_valid   = 1'b0;
        in_inverse = 1'b0;
        out_ready  = 1'b0;
        in_data    = '0;
        repeat (2) tick();
        rst = 1'b0;
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("rst_ov_l%0d", 1 << i), 64'(ov[i]), 64'd0);
            chk($sformatf("rst_od_l%0d", 1 << i), od[i], 64'd0);
            chk($sformatf("rst_ir_l%0d", 1 << i), 64'(ir[i]), 64'd1);
        end

        send(64'd0, 1'b0);
        check_all("zero", 64'd0, 1'b0);
        chk("zero_vec", res[MAIN], 64'hBBBBBBBBBBBBBBBB);

        send(64'h0123456789ABCDEF, 1'b0);
        check_all("fwd", 64'h0123456789ABCDEF, 1'b0);
        chk("fwd_vec", res[MAIN], 64'hBF32AC916780E5D4);
        chk("fwd_vec_l16", res[4], 64'hBF32AC916780E5D4);

        send(64'h0123456789ABCDEF, 1'b1);
        check_all("inv", 64'h0123456789ABCDEF, 1'b1);
        chk("inv_vec", res[MAIN], 64'hB732FD89A6405EC1);

        send(64'hBF32AC916780E5D4, 1'b1);
        chk("roundtrip_vec", res[MAIN], 64'h0123456789ABCDEF);
        chk("roundtrip_vec_l1", res[0], 64'h0123456789ABCDEF);

        for (int t = 0; t < 12; t++) begin
            d   = {$urandom, $urandom};
            inv = 1'($urandom_range(0, 1));
            send(d, inv);
            check_all($sformatf("rand%0d", t), d, inv);
            mid = res[MAIN];
            send(mid, ~inv);
            chk($sformatf("rand%0d_back", t), res[MAIN], d);
        end

        // Backpressure: hold the result while in_valid/in_data wiggle.
        wait_all_idle();
        out_ready  = 1'b0;
        d          = {$urandom, $urandom};
        inv        = 1'($urandom_range(0, 1));
        exp        = ref_sub(d, inv);
        in_data    = d;
        in_inverse = inv;
        in_valid   = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_main_valid();
        for (int c = 0; c < 10; c++) begin
            in_valid   = 1'(c & 1);
            in_data    = {$urandom, $urandom};
            in_inverse = 1'($urandom_range(0, 1));
            tick();
            chk($sformatf("bp_od_%0d", c), od[MAIN], exp);
            chk($sformatf("bp_ov_%0d", c), 64'(ov[MAIN]), 64'd1);
            chk($sformatf("bp_ir_%0d", c), 64'(ir[MAIN]), 64'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("bp_release_ir", 64'(ir[MAIN]), 64'd1);
        chk("bp_release_ov", 64'(ov[MAIN]), 64'd0);
        d = {$urandom, $urandom};
        send(d, 1'b0);
        check_all("bp_next", d, 1'b0);

        // Reset in the second BUSY cycle.
        wait_all_idle();
        in_data  = {$urandom, $urandom};
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_busy_ov", 64'(ov[MAIN]), 64'd0);
        chk("rst_busy_ir", 64'(ir[MAIN]), 64'd1);
        chk("rst_busy_od", od[MAIN], 64'd0);
        no_output("rst_busy_stale");

        // Reset while the result is presented.
        wait_all_idle();
        out_ready = 1'b0;
        in_data   = {$urandom, $urandom};
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_main_valid();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        chk("rst_done_ov", 64'(ov[MAIN]), 64'd0);
        chk("rst_done_ir", 64'(ir[MAIN]), 64'd1);
        chk("rst_done_od", od[MAIN], 64'd0);
        no_output("rst_done_stale");

        send(64'hFFFFFFFFFFFFFFFF, 1'b0);
        check_all("after_rst", 64'hFFFFFFFFFFFFFFFF, 1'b0);
        chk("after_rst_vec", res[MAIN], 64'h4444444444444444);

        // Reset beats a handshake on the same edge.
        wait_all_idle();
        in_data  = {$urandom, $urandom};
        in_valid = 1'b1;
        rst      = 1'b1;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        chk("rst_hs_ir", 64'(ir[MAIN]), 64'd1);
        no_output("rst_hs_stale");

        d = {$urandom, $urandom};
        send(d, 1'b1);
        check_all("final", d, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
